// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants for the EX-stage forwarding / load-use hazard controller.
// Holds forwarding-select encodings, shadow-stage indices and the stage record width.
package hazard_forward_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB1   = 2'b11;

    localparam int ST_EX   = 0;
    localparam int ST_MEM  = 1;
    localparam int ST_WB   = 2;
    localparam int ST_WB1  = 3;
    localparam int N_STAGE = 4;

    // {valid, wr_en, wr_reg, is_load}
    function automatic int stage_w(input int aw);
        return aw + 3;
    endfunction

    localparam int STAGE_W = stage_w(REG_AW_DEF);

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-side bundle into the hazard/forwarding controller and its EX-side select outputs.
// master = pipeline ID stage, slave = hazard_forward_ctrl.
interface hazard_forward_ctrl_if
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int STALL_CW = 16
);
    logic                id_valid;
    logic [REG_AW-1:0]   id_rs;
    logic [REG_AW-1:0]   id_rt;
    logic                id_use_rs;
    logic                id_use_rt;
    logic                id_wr_en;
    logic [REG_AW-1:0]   id_wr_reg;
    logic                id_is_load;
    logic                flush;
    logic [1:0]          fwd_a_sel;
    logic [1:0]          fwd_b_sel;
    logic                stall;
    logic [STALL_CW-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_count
    );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_sel_gen.sv
// Priority encoder for one source operand: youngest matching producer wins.
// A load still in EX cannot forward yet, so it falls through to older stages.
module fwd_sel_gen
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              use_i,
    input  logic              ex_wr_i,
    input  logic [REG_AW-1:0] ex_reg_i,
    input  logic              ex_load_i,
    input  logic              mem_wr_i,
    input  logic [REG_AW-1:0] mem_reg_i,
    input  logic              wb_wr_i,
    input  logic [REG_AW-1:0] wb_reg_i,
    output logic [1:0]        sel_o
);
    logic src_live;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign src_live = use_i && (src_i != '0);
    assign hit_ex   = src_live && ex_wr_i  && (ex_reg_i  == src_i) && !ex_load_i;
    assign hit_mem  = src_live && mem_wr_i && (mem_reg_i == src_i);
    assign hit_wb   = src_live && wb_wr_i  && (wb_reg_i  == src_i);

    always_comb begin
        sel_o = FWD_RF;
        if (hit_ex) begin
            sel_o = FWD_EXMEM;
        end else if (hit_mem) begin
            sel_o = FWD_MEMWB;
        end else if (hit_wb) begin
            sel_o = FWD_WB1;
        end
    end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select generation and load-use stall for the EX operand muxes.
// Keeps a shadow EX/MEM/WB/WB1 pipeline of destination registers; selects are registered.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int STALL_CW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_forward_ctrl_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] wr_reg;
        logic              is_load;
    } stage_t;

    stage_t              stg_q [N_STAGE];
    stage_t              stg_d [N_STAGE];
    logic [1:0]          sel_a_q, sel_a_d;
    logic [1:0]          sel_b_q, sel_b_d;
    logic [STALL_CW-1:0] cnt_q, cnt_d;
    logic [1:0]          sel_a_c, sel_b_c;
    logic                ex_load_wr;
    logic                stall_c;
    logic                take_id;

    fwd_sel_gen #(.REG_AW(REG_AW)) u_sel_a (
        .src_i     (bus.id_rs),
        .use_i     (bus.id_use_rs),
        .ex_wr_i   (stg_q[ST_EX].valid && stg_q[ST_EX].wr_en),
        .ex_reg_i  (stg_q[ST_EX].wr_reg),
        .ex_load_i (stg_q[ST_EX].is_load),
        .mem_wr_i  (stg_q[ST_MEM].valid && stg_q[ST_MEM].wr_en),
        .mem_reg_i (stg_q[ST_MEM].wr_reg),
        .wb_wr_i   (stg_q[ST_WB].valid && stg_q[ST_WB].wr_en),
        .wb_reg_i  (stg_q[ST_WB].wr_reg),
        .sel_o     (sel_a_c)
    );

    fwd_sel_gen #(.REG_AW(REG_AW)) u_sel_b (
        .src_i     (bus.id_rt),
        .use_i     (bus.id_use_rt),
        .ex_wr_i   (stg_q[ST_EX].valid && stg_q[ST_EX].wr_en),
        .ex_reg_i  (stg_q[ST_EX].wr_reg),
        .ex_load_i (stg_q[ST_EX].is_load),
        .mem_wr_i  (stg_q[ST_MEM].valid && stg_q[ST_MEM].wr_en),
        .mem_reg_i (stg_q[ST_MEM].wr_reg),
        .wb_wr_i   (stg_q[ST_WB].valid && stg_q[ST_WB].wr_en),
        .wb_reg_i  (stg_q[ST_WB].wr_reg),
        .sel_o     (sel_b_c)
    );

    assign ex_load_wr = stg_q[ST_EX].valid && stg_q[ST_EX].is_load &&
                        stg_q[ST_EX].wr_en && (stg_q[ST_EX].wr_reg != '0);

    assign stall_c = bus.id_valid && ex_load_wr &&
                     ((bus.id_use_rs && (bus.id_rs == stg_q[ST_EX].wr_reg)) ||
                      (bus.id_use_rt && (bus.id_rt == stg_q[ST_EX].wr_reg)));

    // Flush wins over stall, but the stall is still reported and counted.
    assign take_id = bus.id_valid && !stall_c && !bus.flush;

    always_comb begin
        stg_d[ST_EX]  = '0;
        stg_d[ST_MEM] = stg_q[ST_EX];
        stg_d[ST_WB]  = stg_q[ST_MEM];
        stg_d[ST_WB1] = stg_q[ST_WB];
        sel_a_d       = FWD_RF;
        sel_b_d       = FWD_RF;
        cnt_d         = cnt_q;
        if (take_id) begin
            stg_d[ST_EX] = '{valid: 1'b1, wr_en: bus.id_wr_en,
                             wr_reg: bus.id_wr_reg, is_load: bus.id_is_load};
            sel_a_d      = sel_a_c;
            sel_b_d      = sel_b_c;
        end
        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STAGE; i++) begin
                stg_q[i] <= '0;
            end
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < N_STAGE; i++) begin
                stg_q[i] <= stg_d[i];
            end
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fwd_a_sel   = sel_a_q;
    assign bus.fwd_b_sel   = sel_b_q;
    assign bus.stall       = stall_c;
    assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: driver pushes reference-model expectations,
// a negedge monitor pops and compares stall, selects and the stall counter.
module tb_hazard_forward_ctrl;
    import hazard_forward_ctrl_pkg::*;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.REG_AW(AW), .STALL_CW(CW)) bus ();

    hazard_forward_ctrl #(.REG_AW(AW), .STALL_CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit v; int rs; int rt; bit urs; bit urt; bit wr; int rd; bit ld; bit fl;
    } tins_t;

    typedef struct { bit v; bit wr; int rd; bit ld; } hist_t;

    typedef struct { int due; int a; int b; int cnt; } exp_t;

    hist_t hist[$];      // hist[0] is the instruction now in EX, hist[1] MEM, hist[2] WB
    exp_t  q_sel[$];
    int    q_stall[$];
    int    cnt_m = 0;
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp_v);
        end
    endfunction

    // Value for source r comes from the youngest older instruction that writes r.
    // Distance 1/2/3 maps to EX/MEM, MEM/WB, WB+1; a load one ahead cannot supply yet.
    function automatic int model_sel(input bit use_src, input int r);
        if (!use_src || r == 0) return 0;
        for (int d = 0; d < 3; d++) begin
            if (d < hist.size() && hist[d].v && hist[d].wr && hist[d].rd == r) begin
                if (!(d == 0 && hist[0].ld)) return d + 1;
            end
        end
        return 0;
    endfunction

    function automatic bit model_stall(input tins_t i);
        if (!i.v || hist.size() == 0) return 1'b0;
        if (!(hist[0].v && hist[0].ld && hist[0].wr && hist[0].rd != 0)) return 1'b0;
        return (i.urs && i.rs == hist[0].rd) || (i.urt && i.rt == hist[0].rd);
    endfunction

    function automatic tins_t mk(input bit v, input int rs, input int rt, input bit urs,
                                 input bit urt, input bit wr, input int rd, input bit ld,
                                 input bit fl);
        tins_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
        t.wr = wr; t.rd = rd; t.ld = ld; t.fl = fl;
        return t;
    endfunction

    function automatic tins_t alu(input int rd, input int rs, input int rt);
        return mk(1, rs, rt, 1, 1, 1, rd, 0, 0);
    endfunction

    function automatic tins_t lw(input int rd, input int rs);
        return mk(1, rs, 0, 1, 0, 1, rd, 1, 0);
    endfunction

    function automatic tins_t nop();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Called at posedge+1: drive ID, record expectations, advance to next posedge+1.
    task automatic step(input tins_t i, output bit st);
        bit    take;
        hist_t h;
        exp_t  e;
        bus.id_valid   = i.v;
        bus.id_rs      = AW'(i.rs);
        bus.id_rt      = AW'(i.rt);
        bus.id_use_rs  = i.urs;
        bus.id_use_rt  = i.urt;
        bus.id_wr_en   = i.wr;
        bus.id_wr_reg  = AW'(i.rd);
        bus.id_is_load = i.ld;
        bus.flush      = i.fl;
        st   = model_stall(i);
        take = i.v && !st && !i.fl;
        q_stall.push_back(int'(st));
        e.due = cyc + 1;
        e.a   = take ? model_sel(i.urs, i.rs) : 0;
        e.b   = take ? model_sel(i.urt, i.rt) : 0;
        if (st && cnt_m < CNT_MAX) cnt_m++;
        e.cnt = cnt_m;
        q_sel.push_back(e);
        h.v = take; h.wr = take && i.wr; h.rd = take ? i.rd : 0; h.ld = take && i.ld;
        hist.push_front(h);
        if (hist.size() > 4) void'(hist.pop_back());
        @(posedge clk);
        #1;
    endtask

    // A stalled instruction stays in ID and is presented again.
    task automatic issue(input tins_t i);
        bit st;
        int tries = 0;
        do begin
            step(i, st);
            tries++;
        end while (st && !i.fl && tries < 3);
        if (st && !i.fl) chk("stall_len", tries, 2);
    endtask

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0;
        bus.id_use_rt = 0; bus.id_wr_en = 0; bus.id_wr_reg = '0; bus.id_is_load = 0;
        bus.flush = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        q_sel.delete();
        q_stall.delete();
        hist.delete();
        cnt_m = 0;
        #2;
        chk("rst_sel_a", int'(bus.fwd_a_sel), 0);
        chk("rst_sel_b", int'(bus.fwd_b_sel), 0);
        chk("rst_count", int'(bus.stall_count), 0);
        chk("rst_stall", int'(bus.stall), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q_stall.size() > 0) chk("stall", int'(bus.stall), q_stall.pop_front());
            while (q_sel.size() > 0 && q_sel[0].due <= cyc) begin
                exp_t e;
                e = q_sel.pop_front();
                chk("fwd_a_sel", int'(bus.fwd_a_sel), e.a);
                chk("fwd_b_sel", int'(bus.fwd_b_sel), e.b);
                chk("stall_count", int'(bus.stall_count), e.cnt);
            end
        end
    end

    initial begin
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        issue(alu(3, 1, 2)); issue(alu(4, 3, 5));
        issue(alu(3, 1, 2)); issue(nop()); issue(alu(6, 2, 3));
        issue(alu(3, 1, 2)); issue(nop()); issue(nop()); issue(alu(6, 2, 3));
        issue(alu(3, 1, 2)); issue(nop()); issue(nop()); issue(nop()); issue(alu(6, 2, 3));
        issue(lw(8, 1)); issue(alu(9, 8, 8));
        issue(alu(0, 1, 2)); issue(alu(1, 0, 0));
        issue(lw(0, 1)); issue(alu(2, 0, 0));
        issue(alu(7, 1, 1)); issue(alu(7, 2, 2)); issue(alu(2, 7, 1));
        issue(mk(1, 1, 0, 1, 0, 1, 8, 1, 1)); issue(alu(9, 8, 8));
        issue(lw(10, 1)); issue(mk(1, 10, 10, 1, 1, 1, 11, 0, 1)); issue(alu(12, 10, 0));

        for (int k = 0; k < 20; k++) begin
            issue(lw(5, 0)); issue(alu(6, 5, 1));
        end

        for (int k = 0; k < 150; k++) begin
            tins_t t;
            t = mk(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 9) == 0));
            issue(t);
        end

        do_reset();
        issue(alu(3, 1, 2)); issue(alu(4, 3, 3)); issue(lw(8, 1)); issue(alu(9, 8, 0));

        for (int k = 0; k < 150; k++) begin
            tins_t t;
            t = mk(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 9) == 0));
            issue(t);
        end

        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", q_sel.size() + q_stall.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
